// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch sequencer: FSM states, redirect source codes and PC step.
package pc_ctrl_pkg;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_EXC  = 3'd3,
        SRC_PEND = 3'd4
    } src_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select: exc > jump > branch > pending > sequential.
// Build option ALIGN_CHECK_EN: misaligned branch/jump targets become EXC_VEC and flag a fault.
module pc_next_mux
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(32'h80)
) (
    input  logic [ADDR_W-1:0] seq_pc,
    input  logic              exc_req,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect,
    output logic              align_fault
);

    src_t              src;
    logic [ADDR_W-1:0] raw_pc;
    logic              misaligned;

    always_comb begin
        src = SRC_SEQ;
        if (exc_req) begin
            src = SRC_EXC;
        end else if (jump) begin
            src = SRC_JMP;
        end else if (branch_taken) begin
            src = SRC_BR;
        end else if (pend_valid) begin
            src = SRC_PEND;
        end
    end

    always_comb begin
        raw_pc = seq_pc;
        case (src)
            SRC_EXC:  raw_pc = EXC_VEC;
            SRC_JMP:  raw_pc = jump_target;
            SRC_BR:   raw_pc = branch_target;
            SRC_PEND: raw_pc = pend_addr;
            default:  raw_pc = seq_pc;
        endcase
    end

    // Pending addresses were already sanitised when latched; only live targets are checked.
    assign misaligned = ((src == SRC_JMP) || (src == SRC_BR)) && (raw_pc[1:0] != 2'b00);
    assign redirect   = (src != SRC_SEQ);

`ifdef ALIGN_CHECK_EN
    assign next_pc     = misaligned ? EXC_VEC : raw_pc;
    assign align_fault = misaligned;
`else
    assign next_pc     = misaligned ? {raw_pc[ADDR_W-1:2], 2'b00} : raw_pc;
    assign align_fault = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem req/ack handshake and registers fetched words.
// Build option ALIGN_CHECK_EN: misaligned redirect targets fault to EXC_VEC instead of being truncated.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h80),
    parameter int unsigned       MAX_WAIT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              exc_req,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_fault
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              req_q, req_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] pc_plus4_c;
    logic [ADDR_W-1:0] next_pc_c;
    logic              redirect_c;
    logic              align_fault_c;
    logic              timeout_c;

    assign pc_plus4_c = pc_q + ADDR_W'(PC_INC);
    assign timeout_c  = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

    pc_next_mux #(
        .ADDR_W  (ADDR_W),
        .EXC_VEC (EXC_VEC)
    ) u_next_mux (
        .seq_pc        (pc_plus4_c),
        .exc_req       (exc_req),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pend_valid    (pend_valid_q),
        .pend_addr     (pend_addr_q),
        .next_pc       (next_pc_c),
        .redirect      (redirect_c),
        .align_fault   (align_fault_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_addr_d   = pend_addr_q;
        pend_valid_d  = pend_valid_q;
        wait_cnt_d    = wait_cnt_q;
        instr_valid_d = 1'b0;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q | align_fault_c;

        case (state_q)
            S_BOOT: begin
                // No request outstanding, so a redirect can be taken directly.
                if (redirect_c) begin
                    pc_d = next_pc_c;
                end
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    pc_d         = next_pc_c;
                    wait_cnt_d   = '0;
                    pend_valid_d = 1'b0;
                    if (!redirect_c) begin
                        instr_valid_d = 1'b1;
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                    end
                    state_d = stall ? S_HOLD : S_FETCH;
                end else if (timeout_c) begin
                    // Drop req for one cycle so a late ack of the dead request is ignored.
                    pc_d         = EXC_VEC;
                    fault_d      = 1'b1;
                    pend_valid_d = 1'b0;
                    wait_cnt_d   = '0;
                    state_d      = S_BOOT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (redirect_c) begin
                        pend_addr_d  = next_pc_c;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_c) begin
                    pc_d = next_pc_c;
                end
                if (!stall) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        req_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_VEC;
            pend_addr_q   <= '0;
            pend_valid_q  <= 1'b0;
            wait_cnt_q    <= '0;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_addr_q   <= pend_addr_d;
            pend_valid_q  <= pend_valid_d;
            wait_cnt_q    <= wait_cnt_d;
            req_q         <= req_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_plus4_c;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: scenario tasks plus a fetched-word scoreboard.
// Honours ALIGN_CHECK_EN to pick the expected alignment behaviour.
module tb_pc_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        exc_req = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    fetch_t exp_q[$];
    fetch_t obs_q[$];

    pc_fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exc_req       (exc_req),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    // Every decode-valid pulse is captured for the scoreboard.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) obs_q.push_back({instr_pc, instr_out});
    end

    function automatic fetch_t mk(input logic [31:0] p, input logic [31:0] i);
        mk = {p, i};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (imem_req !== 1'b0 || pc_out !== 32'h0) begin
            errors++; $display("FAIL reset_state: req=%b pc=%h want req=0 pc=0", imem_req, pc_out);
        end
        checks++;
        if ({instr_valid, fetch_fault, instr_out, instr_pc} !== 66'h0) begin
            errors++; $display("FAIL reset_regs: valid=%b fault=%b instr=%h ipc=%h want all 0", instr_valid, fetch_fault, instr_out, instr_pc);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL boot_fetch: req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        imem_rdata = 32'h1111_1111; imem_ack = 1'b1;
        exp_q.push_back(mk(32'h0, 32'h1111_1111));
        tick();
        imem_ack = 1'b0;
        checks++;
        if (pc_out !== 32'h4) begin
            errors++; $display("FAIL first_ack_pc: got %h want 00000004", pc_out);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc_out !== 32'h0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: req=%b pc=%h valid=%b want 0/0/0", imem_req, pc_out, instr_valid);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL refetch: req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        #1;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            fetch_t e = exp_q.pop_front();
            fetch_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL sb_reset: got pc=%h instr=%h want pc=%h instr=%h", o.pc, o.instr, e.pc, e.instr); end
        end
        checks++;
        if (exp_q.size() != obs_q.size()) begin
            errors++; $display("FAIL sb_reset_count: extra obs=%0d exp=%0d want equal", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_seq();
        imem_rdata = 32'h2008_0005; imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(32'(4 * k), 32'h2008_0005));
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k)) begin
                errors++; $display("FAIL seq_valid%0d: valid=%b ipc=%h want 1/%h", k, instr_valid, instr_pc, 32'(4 * k));
            end
            checks++;
            if (pc_out !== 32'(4 * k + 4) || pc_plus4 !== 32'(4 * k + 8)) begin
                errors++; $display("FAIL seq_pc%0d: pc=%h plus4=%h want %h/%h", k, pc_out, pc_plus4, 32'(4 * k + 4), 32'(4 * k + 8));
            end
        end
        imem_ack = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL seq_noack: valid=%b want 0", instr_valid);
        end
        #1;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            fetch_t e = exp_q.pop_front();
            fetch_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL sb_seq: got pc=%h instr=%h want pc=%h instr=%h", o.pc, o.instr, e.pc, e.instr); end
        end
        checks++;
        if (exp_q.size() != obs_q.size()) begin
            errors++; $display("FAIL sb_seq_count: obs=%0d exp=%0d want equal", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_branch();
        // Branch two cycles before the ack of the fetch at 0xC: word must be dropped.
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            errors++; $display("FAIL br_hold_req: req=%b addr=%h want 1/0000000c", imem_req, imem_addr);
        end
        tick();
        imem_rdata = 32'hDEAD_BEEF; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h40) begin
            errors++; $display("FAIL br_discard: valid=%b addr=%h want 0/00000040", instr_valid, imem_addr);
        end
        imem_rdata = 32'h0A0A_0A0A; imem_ack = 1'b1;
        exp_q.push_back(mk(32'h40, 32'h0A0A_0A0A));
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || pc_out !== 32'h44) begin
            errors++; $display("FAIL br_target_fetch: valid=%b ipc=%h pc=%h want 1/40/44", instr_valid, instr_pc, pc_out);
        end
        // Live branch in the ack cycle also discards.
        branch_taken = 1'b1; branch_target = 32'h180; imem_rdata = 32'h3333_3333;
        tick();
        branch_taken = 1'b0; imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc_out !== 32'h180) begin
            errors++; $display("FAIL br_live_ack: valid=%b pc=%h want 0/00000180", instr_valid, pc_out);
        end
        branch_taken = 1'b1; branch_target = 32'h60;
        tick();
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h200;
        tick();
        jump = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc_out !== 32'h200) begin
            errors++; $display("FAIL pend_overwrite: valid=%b pc=%h want 0/00000200", instr_valid, pc_out);
        end
        #1;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            fetch_t e = exp_q.pop_front();
            fetch_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL sb_branch: got pc=%h instr=%h want pc=%h instr=%h", o.pc, o.instr, e.pc, e.instr); end
        end
        checks++;
        if (exp_q.size() != obs_q.size()) begin
            errors++; $display("FAIL sb_branch_count: obs=%0d exp=%0d want equal", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_hold();
        stall = 1'b1;
        tick(); tick();
        checks++;
        if (imem_req !== 1'b1 || pc_out !== 32'h200) begin
            errors++; $display("FAIL stall_in_fetch: req=%b pc=%h want 1/00000200", imem_req, pc_out);
        end
        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        exp_q.push_back(mk(32'h200, 32'h5555_AAAA));
        tick();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || pc_out !== 32'h204 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL enter_hold: req=%b pc=%h valid=%b want 0/204/1", imem_req, pc_out, instr_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b0 || pc_out !== 32'h204) begin
            errors++; $display("FAIL hold_pc: req=%b pc=%h want 0/00000204", imem_req, pc_out);
        end
        exc_req = 1'b1; jump = 1'b1; jump_target = 32'h100;
        tick();
        exc_req = 1'b0; jump = 1'b0;
        checks++;
        if (pc_out !== 32'h80 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL hold_exc_prio: pc=%h req=%b valid=%b want 80/0/0", pc_out, imem_req, instr_valid);
        end
        stall = 1'b0; jump = 1'b1; jump_target = 32'h300;
        tick();
        jump = 1'b0;
        checks++;
        if (pc_out !== 32'h300 || imem_req !== 1'b1) begin
            errors++; $display("FAIL hold_release: pc=%h req=%b want 00000300/1", pc_out, imem_req);
        end
        #1;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            fetch_t e = exp_q.pop_front();
            fetch_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL sb_hold: got pc=%h instr=%h want pc=%h instr=%h", o.pc, o.instr, e.pc, e.instr); end
        end
        checks++;
        if (exp_q.size() != obs_q.size()) begin
            errors++; $display("FAIL sb_hold_count: obs=%0d exp=%0d want equal", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_timeout();
        repeat (14) tick();
        checks++;
        if (pc_out !== 32'h300 || fetch_fault !== 1'b0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL pre_timeout: pc=%h fault=%b req=%b want 300/0/1", pc_out, fetch_fault, imem_req);
        end
        tick();
        checks++;
        if (pc_out !== 32'h80 || fetch_fault !== 1'b1) begin
            errors++; $display("FAIL timeout: pc=%h fault=%b want 00000080/1", pc_out, fetch_fault);
        end
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL late_ack: valid=%b want 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80 || fetch_fault !== 1'b1) begin
            errors++; $display("FAIL post_timeout: valid=%b req=%b addr=%h fault=%b want 0/1/80/1", instr_valid, imem_req, imem_addr, fetch_fault);
        end
        #1;
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL sb_timeout: got %0d words want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_align();
        reset = 1'b0;
        tick();
        checks++;
        if (fetch_fault !== 1'b0) begin
            errors++; $display("FAIL fault_reset: got %b want 0", fetch_fault);
        end
        reset = 1'b1;
        tick();
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0077;
        exp_q.push_back(mk(32'h0, 32'h0000_0077));
        tick();
        imem_ack = 1'b0; jump = 1'b1; jump_target = 32'h102;
        tick();
        jump = 1'b0;
`ifdef ALIGN_CHECK_EN
        checks++;
        if (pc_out !== 32'h80 || fetch_fault !== 1'b1) begin
            errors++; $display("FAIL align_fault: pc=%h fault=%b want 00000080/1", pc_out, fetch_fault);
        end
`else
        checks++;
        if (pc_out !== 32'h100 || fetch_fault !== 1'b0) begin
            errors++; $display("FAIL align_trunc: pc=%h fault=%b want 00000100/0", pc_out, fetch_fault);
        end
`endif
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        checks++;
        if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL plus4_wrap: pc=%h plus4=%h want fffffffc/00000000", pc_out, pc_plus4);
        end
        stall = 1'b0;
        #1;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            fetch_t e = exp_q.pop_front();
            fetch_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL sb_align: got pc=%h instr=%h want pc=%h instr=%h", o.pc, o.instr, e.pc, e.instr); end
        end
        checks++;
        if (exp_q.size() != obs_q.size()) begin
            errors++; $display("FAIL sb_align_count: obs=%0d exp=%0d want equal", obs_q.size(), exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_seq();
        test_branch();
        test_hold();
        test_timeout();
        test_align();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
